// File: rtl/reg_select_sequencer.sv
// rtl/reg_select_sequencer.sv - register select sequencer driving one-hot register file enables
// Latches Ra/Rb/Rc and op class on start, then walks out/in phases with registered enables.
module reg_select_sequencer (
   input  logic        clk,
   input  logic        clr_n,
   input  logic        start,
   input  logic [31:0] ir,
   input  logic [1:0]  op_class,
   input  logic        base_zero,
   input  logic        stall,
   output logic [15:0] r_out,
   output logic [15:0] r_in,
   output logic        zero_out,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      S_IDLE, S_RB_OUT, S_RC_OUT, S_RA_IN, S_RA_OUT, S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
   logic [1:0]  cls_q, cls_d;
   logic        bz_q, bz_d;
   logic        stalled_q, stalled_d;
   logic [15:0] r_out_q, r_out_d, r_in_q, r_in_d;
   logic        zero_out_q, zero_out_d, busy_q, busy_d, done_q, done_d;
   logic        present;
   logic        unused_ir;

   assign unused_ir = ^{ir[31:27], ir[14:0]};

   function automatic logic [15:0] dec(input logic [3:0] n);
      dec = 16'h0001 << n;
   endfunction

   function automatic state_t first_phase(input logic [1:0] c);
      case (c)
         2'b00, 2'b01: first_phase = S_RB_OUT;
         2'b10:        first_phase = S_RA_IN;
         default:      first_phase = S_RA_OUT;
      endcase
   endfunction

   always_comb begin
      state_d   = state_q;
      ra_d      = ra_q;
      rb_d      = rb_q;
      rc_d      = rc_q;
      cls_d     = cls_q;
      bz_d      = bz_q;
      stalled_d = 1'b0;
      present   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               ra_d    = ir[26:23];
               rb_d    = ir[22:19];
               rc_d    = ir[18:15];
               cls_d   = op_class;
               bz_d    = base_zero;
               state_d = first_phase(op_class);
               present = 1'b1;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: begin
            // After a stall the held phase must show its enable once more before moving on.
            if (stall) begin
               stalled_d = 1'b1;
            end else if (stalled_q) begin
               present = 1'b1;
            end else begin
               present = 1'b1;
               case (state_q)
                  S_RB_OUT: state_d = (cls_q == 2'b00) ? S_RC_OUT : S_RA_IN;
                  S_RC_OUT: state_d = S_RA_IN;
                  default:  state_d = S_DONE;
               endcase
            end
         end
      endcase

      r_out_d    = 16'h0000;
      r_in_d     = 16'h0000;
      zero_out_d = 1'b0;
      if (present) begin
         case (state_d)
            S_RB_OUT: begin
               if (bz_d && (rb_d == 4'd0)) zero_out_d = 1'b1;
               else                        r_out_d    = dec(rb_d);
            end
            S_RC_OUT: r_out_d = dec(rc_d);
            S_RA_OUT: r_out_d = dec(ra_d);
            S_RA_IN:  r_in_d  = dec(ra_d);
            default:  ;
         endcase
      end
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q    <= S_IDLE;
         ra_q       <= 4'd0;
         rb_q       <= 4'd0;
         rc_q       <= 4'd0;
         cls_q      <= 2'd0;
         bz_q       <= 1'b0;
         stalled_q  <= 1'b0;
         r_out_q    <= 16'h0000;
         r_in_q     <= 16'h0000;
         zero_out_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ra_q       <= ra_d;
         rb_q       <= rb_d;
         rc_q       <= rc_d;
         cls_q      <= cls_d;
         bz_q       <= bz_d;
         stalled_q  <= stalled_d;
         r_out_q    <= r_out_d;
         r_in_q     <= r_in_d;
         zero_out_q <= zero_out_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign r_out    = r_out_q;
   assign r_in     = r_in_q;
   assign zero_out = zero_out_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_reg_select_sequencer.sv
// tb/tb_reg_select_sequencer.sv - randomized and directed bench for reg_select_sequencer
module tb_reg_select_sequencer;

   logic        clk = 1'b0;
   logic        clr_n, start, base_zero, stall;
   logic [31:0] ir;
   logic [1:0]  op_class;
   logic [15:0] r_out, r_in;
   logic        zero_out, busy, done;

   int checks = 0;
   int errors = 0;

   localparam int P_RB = 0, P_RC = 1, P_RAIN = 2, P_RAOUT = 3, P_DONE = 4, P_IDLE = 5;

   int         m_queue[$];
   int         m_cur = P_IDLE;
   bit         m_pres, m_stalled, m_bz;
   logic [3:0] m_ra, m_rb, m_rc;

   reg_select_sequencer dut (
      .clk(clk), .clr_n(clr_n), .start(start), .ir(ir), .op_class(op_class),
      .base_zero(base_zero), .stall(stall), .r_out(r_out), .r_in(r_in),
      .zero_out(zero_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk_ir(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
      logic [4:0]  hi;
      logic [14:0] lo;
      hi = 5'($urandom);
      lo = 15'($urandom);
      return {hi, ra, rb, rc, lo};
   endfunction

   task automatic model_reset();
      m_queue.delete();
      m_cur = P_IDLE; m_pres = 0; m_stalled = 0; m_bz = 0;
      m_ra = 0; m_rb = 0; m_rc = 0;
   endtask

   task automatic model_edge(input bit s, input logic [31:0] i, input logic [1:0] c, input bit bz, input bit st);
      if (m_cur == P_IDLE) begin
         if (s) begin
            m_ra = i[26:23]; m_rb = i[22:19]; m_rc = i[18:15]; m_bz = bz;
            case (c)
               2'b00:   m_queue = '{P_RB, P_RC, P_RAIN};
               2'b01:   m_queue = '{P_RB, P_RAIN};
               2'b10:   m_queue = '{P_RAIN};
               default: m_queue = '{P_RAOUT};
            endcase
            m_cur = m_queue.pop_front();
            m_pres = 1; m_stalled = 0;
         end
      end else if (m_cur == P_DONE) begin
         m_cur = P_IDLE; m_pres = 0;
      end else if (st) begin
         m_pres = 0; m_stalled = 1;
      end else if (m_stalled) begin
         m_pres = 1; m_stalled = 0;
      end else begin
         m_cur = (m_queue.size() == 0) ? P_DONE : m_queue.pop_front();
         m_pres = 1;
      end
   endtask

   task automatic compare_all();
      logic [15:0] e_out, e_in;
      logic        e_z;
      e_out = 16'h0; e_in = 16'h0; e_z = 1'b0;
      if (m_pres) begin
         case (m_cur)
            P_RB:    if (m_bz && m_rb == 4'd0) e_z = 1'b1; else e_out = 16'd1 << m_rb;
            P_RC:    e_out = 16'd1 << m_rc;
            P_RAOUT: e_out = 16'd1 << m_ra;
            P_RAIN:  e_in  = 16'd1 << m_ra;
            default: ;
         endcase
      end
      check("r_out", r_out, e_out);
      check("r_in", r_in, e_in);
      check("zero_out", zero_out, e_z);
      check("busy", busy, m_cur != P_IDLE);
      check("done", done, m_cur == P_DONE);
      check("onehot", ($countones(r_out | r_in) <= 1) && !(r_out != 0 && r_in != 0), 1);
   endtask

   task automatic step(input bit s, input logic [31:0] i, input logic [1:0] c, input bit bz, input bit st);
      start = s; ir = i; op_class = c; base_zero = bz; stall = st;
      @(posedge clk);
      model_edge(s, i, c, bz, st);
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle_step(input bit st);
      step(1'b0, $urandom, 2'($urandom), 1'($urandom), st);
   endtask

   initial begin
      model_reset();
      clr_n = 1'b0; start = 0; ir = 0; op_class = 0; base_zero = 0; stall = 0;
      @(negedge clk);
      check("rst_r_out", r_out, 0);
      check("rst_r_in", r_in, 0);
      check("rst_zero", zero_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      clr_n = 1'b1;

      // class 00: Ra=5 Rb=2 Rc=7
      step(1, mk_ir(5, 2, 7), 2'b00, 0, 0); check("c00_rb", r_out, 16'h0004);
      idle_step(0);                         check("c00_rc", r_out, 16'h0080);
      idle_step(0);                         check("c00_ra_in", r_in, 16'h0020);
      idle_step(0);                         check("c00_done", done, 1);
      idle_step(0);                         check("c00_idle", busy, 0);

      // class 01 with base_zero, then without
      step(1, mk_ir(15, 0, 4'($urandom)), 2'b01, 1, 0);
      check("c01_zero", zero_out, 1); check("c01_rout0", r_out, 16'h0000);
      idle_step(0); check("c01_rin", r_in, 16'h8000);
      idle_step(0); check("c01_done", done, 1);
      idle_step(0);
      step(1, mk_ir(15, 0, 4'($urandom)), 2'b01, 0, 0);
      check("c01_nz_rout", r_out, 16'h0001); check("c01_nz_zero", zero_out, 0);
      idle_step(0); idle_step(0); idle_step(0);

      // class 00 with two stalled edges in RC_OUT
      step(1, mk_ir(5, 2, 7), 2'b00, 0, 0); check("st_rb", r_out, 16'h0004);
      idle_step(0); check("st_rc", r_out, 16'h0080);
      idle_step(1); check("st_hold1", r_out, 16'h0000);
      idle_step(1); check("st_hold2", r_out, 16'h0000);
      idle_step(0); check("st_rc_again", r_out, 16'h0080);
      idle_step(0); check("st_ra_in", r_in, 16'h0020);
      idle_step(0); check("st_done", done, 1);
      idle_step(0);

      // class 11 with start and new ir while busy
      step(1, mk_ir(9, 1, 2), 2'b11, 0, 0); check("c11_rout", r_out, 16'h0200);
      step(1, mk_ir(4, 1, 2), 2'b00, 0, 0); check("c11_done", done, 1);
      step(1, mk_ir(6, 3, 3), 2'b10, 0, 0); check("c11_idle", busy, 0);
      check("c11_no_rin", r_in, 16'h0000);

      // class 10 aborted by async reset during RA_IN
      step(1, mk_ir(3, 0, 0), 2'b10, 0, 0); check("c10_rin", r_in, 16'h0008);
      #2 clr_n = 1'b0;
      #1;
      check("arst_rin", r_in, 0); check("arst_busy", busy, 0);
      check("arst_rout", r_out, 0); check("arst_done", done, 0);
      model_reset();
      @(negedge clk);
      clr_n = 1'b1;
      idle_step(0); check("arst_idle", busy, 0);
      step(1, mk_ir(3, 0, 0), 2'b10, 0, 0); check("c10_again", r_in, 16'h0008);
      idle_step(0); idle_step(0);

      // sweep Ra with class 10
      for (int ra = 0; ra < 16; ra++) begin
         step(1, mk_ir(4'(ra), 4'($urandom), 4'($urandom)), 2'b10, 1'($urandom), 0);
         check("sweep_rin", r_in, 32'h1 << ra);
         idle_step(0); idle_step(0);
      end

      // random sequences with stalls and stray starts
      for (int n = 0; n < 60; n++) begin
         int steps;
         steps = 0;
         step(1, $urandom, 2'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
         while (m_cur != P_IDLE && steps < 40) begin
            step($urandom_range(0, 3) == 0, $urandom, 2'($urandom), 1'($urandom),
                 (steps < 20) && ($urandom_range(0, 3) == 0));
            steps++;
         end
         if (m_cur != P_IDLE) check("seq_timeout", 0, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
